// File: rtl/trinity_trit_pkg.sv
// Shared trit encodings and FSM state type for the gene mutator.
package trinity_trit_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_Z   = 2'b00;
    localparam trit_t TRIT_P   = 2'b01;
    localparam trit_t TRIT_N   = 2'b10;
    localparam trit_t TRIT_INV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/trinity_trit_adder.sv
// Combinational balanced-ternary trit adder used on the genome RMW path.
// Default: saturating (P+P=P, N+N=N).
// TRINITY_TRIT_WRAP_EN: modular balanced ternary (P+P=N, N+N=P, carry dropped).
// An 11 encoding on either operand is treated as Z.
module trinity_trit_adder
    import trinity_trit_pkg::*;
(
    input  trit_t a,
    input  trit_t b,
    output trit_t y
);

    trit_t a_eff;
    trit_t b_eff;

    // Sum of two trits; only the equal-nonzero case depends on the build option.
    always_comb begin
        a_eff = (a == TRIT_INV) ? TRIT_Z : a;
        b_eff = (b == TRIT_INV) ? TRIT_Z : b;
        y     = a_eff;
        if (b_eff == TRIT_Z) begin
            y = a_eff;
        end else if (a_eff == TRIT_Z) begin
            y = b_eff;
        end else if (a_eff != b_eff) begin
            y = TRIT_Z;
        end else begin
`ifdef TRINITY_TRIT_WRAP_EN
            y = (a_eff == TRIT_P) ? TRIT_N : TRIT_P;
`else
            y = a_eff;
`endif
        end
    end

endmodule

// File: rtl/trinity_gene_mutator.sv
// Consumer of the mutation stream: holds the genome, applies one mutation trit
// per accepted handshake to genome[ptr], sweeping the genome once per start.
// Optional build macro TRINITY_TRIT_WRAP_EN selects wrapping trit addition
// (handled inside trinity_trit_adder).
module trinity_gene_mutator
    import trinity_trit_pkg::*;
#(
    parameter int GENOME_LEN = 27,
    parameter int ADDR_W     = $clog2(GENOME_LEN),
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mut_valid,
    input  logic [1:0]        mut_trit,
    output logic              mut_ready,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_trit,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_trit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  mut_count,
    output logic              err_sticky
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(GENOME_LEN - 1);

    state_t                  state, state_nxt;
    trit_t [GENOME_LEN-1:0]  genome;
    logic  [ADDR_W-1:0]      ptr;
    trit_t                   cur_trit;
    trit_t                   sum_trit;
    logic                    accept;
    logic                    start_ok;
    logic                    ld_ok;

    assign accept   = mut_valid & (state == RUN);
    assign start_ok = start & (state == IDLE);
    // Loads only land in IDLE and only for addresses inside the genome.
    assign ld_ok    = ld_we & (state == IDLE) & (ld_addr <= LAST);
    assign cur_trit = genome[ptr];

    assign mut_ready = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    trinity_trit_adder u_add (
        .a (cur_trit),
        .b (mut_trit),
        .y (sum_trit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one sweep per start, DONE lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && (ptr == LAST)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Genome storage, sweep pointer, mutation counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            genome     <= '0;
            ptr        <= '0;
            mut_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (start_ok) begin
                ptr        <= '0;
                mut_count  <= '0;
                err_sticky <= 1'b0;
            end
            if (ld_ok)
                genome[ld_addr] <= (ld_trit == TRIT_INV) ? TRIT_Z : ld_trit;
            if (accept) begin
                genome[ptr] <= sum_trit;
                ptr         <= (ptr == LAST) ? '0 : ptr + 1'b1;
                if (mut_trit == TRIT_INV)
                    err_sticky <= 1'b1;
                else if ((mut_trit != TRIT_Z) && !(&mut_count))
                    mut_count <= mut_count + 1'b1;
            end
        end
    end

    // Registered readout; sees the pre-write value on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              rd_trit <= TRIT_Z;
        else if (rd_addr <= LAST) rd_trit <= genome[rd_addr];
        else                     rd_trit <= TRIT_Z;
    end

endmodule

// File: tb/tb_trinity_gene_mutator.sv
// Directed self-checking bench for trinity_gene_mutator (default parameters).
module tb_trinity_gene_mutator;

    localparam int GL = 27;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mut_valid = 1'b0;
    logic [1:0]    mut_trit = 2'b00;
    logic          mut_ready;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [1:0]    ld_trit = 2'b00;
    logic [AW-1:0] rd_addr = '0;
    logic [1:0]    rd_trit;
    logic          busy;
    logic          done;
    logic [CW-1:0] mut_count;
    logic          err_sticky;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ptr_m = 0;
    logic [1:0] exp_g [GL];

    trinity_gene_mutator #(.GENOME_LEN(GL), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mut_valid(mut_valid),
        .mut_trit(mut_trit), .mut_ready(mut_ready), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_trit(ld_trit), .rd_addr(rd_addr),
        .rd_trit(rd_trit), .busy(busy), .done(done), .mut_count(mut_count),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #300000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Reference trit addition written from the behavioural description.
    function automatic logic [1:0] tadd(input logic [1:0] a, input logic [1:0] b);
        if (b == 2'b00 || b == 2'b11) return a;
        if (a == 2'b00) return b;
        if (a != b) return 2'b00;
`ifdef TRINITY_TRIT_WRAP_EN
        return (a == 2'b01) ? 2'b10 : 2'b01;
`else
        return a;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [1:0] t);
        ld_we = 1'b1; ld_addr = AW'(a); ld_trit = t;
        tick();
        ld_we = 1'b0;
        if (a < GL) exp_g[a] = (t == 2'b11) ? 2'b00 : t;
    endtask

    task automatic rd(input int a, output logic [1:0] v);
        rd_addr = AW'(a);
        tick();
        v = rd_trit;
    endtask

    task automatic start_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        ptr_m = 0;
    endtask

    task automatic send(input logic [1:0] t, input int gap);
        mut_valid = 1'b1; mut_trit = t;
        exp_g[ptr_m] = tadd(exp_g[ptr_m], t);
        ptr_m = (ptr_m + 1) % GL;
        tick();
        mut_valid = 1'b0; mut_trit = 2'b00;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        logic [1:0] v;
        rst_n = 1'b0;
        for (int i = 0; i < GL; i++) exp_g[i] = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (mut_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", mut_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mut_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", mut_count); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_sticky); end
        for (int i = 0; i < GL; i++) begin
            rd(i, v);
            checks++; if (v !== 2'b00) begin errors++; $display("FAIL reset_trit[%0d] got %b want 00", i, v); end
        end
        rd(31, v);
        checks++; if (v !== 2'b00) begin errors++; $display("FAIL rd_oob got %b want 00", v); end
    endtask

    task automatic test_load();
        logic [1:0] v;
        load(7, 2'b01);
        rd(7, v);
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL load_p got %b want 01", v); end
        // write 11 to addr 7 while reading it in the same cycle
        ld_we = 1'b1; ld_addr = 5'd7; ld_trit = 2'b11; rd_addr = 5'd7;
        tick();
        ld_we = 1'b0;
        exp_g[7] = 2'b00;
        checks++; if (rd_trit !== 2'b01) begin errors++; $display("FAIL rd_during_wr got %b want 01", rd_trit); end
        tick();
        checks++; if (rd_trit !== 2'b00) begin errors++; $display("FAIL load_inv got %b want 00", rd_trit); end
    endtask

    task automatic test_single();
        logic [1:0] v;
        load(0, 2'b01);
        start_sweep();
        checks++; if (busy !== 1'b1 || mut_ready !== 1'b1) begin errors++; $display("FAIL run_entry got busy=%b ready=%b want 1/1", busy, mut_ready); end
        send(2'b01, 0);
        checks++; if (mut_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", mut_count); end
        for (int i = 1; i < GL; i++) send(2'b00, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", done); end
        tick();
        rd(0, v);
`ifdef TRINITY_TRIT_WRAP_EN
        checks++; if (v !== 2'b10) begin errors++; $display("FAIL single_g0 got %b want 10", v); end
`else
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL single_g0 got %b want 01", v); end
`endif
    endtask

    task automatic test_full_sweep();
        logic [1:0] v;
        logic [1:0] pat;
        int d0;
        d0 = done_cnt;
        start_sweep();
        for (int i = 0; i < GL; i++) begin
            pat = (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b00;
            send(pat, (i == GL - 1) ? 0 : i % 4);
        end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL sweep_early_done got %0d want 0", done_cnt - d0); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sweep_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_busy got %b want 0", busy); end
        checks++; if (mut_count !== 16'd18) begin errors++; $display("FAIL sweep_count got %0d want 18", mut_count); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sweep_done_len got %b want 0", done); end
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL sweep_done_pulses got %0d want 1", done_cnt - d0); end
        for (int i = 0; i < GL; i++) begin
            rd(i, v);
            checks++; if (v !== exp_g[i]) begin errors++; $display("FAIL sweep_g[%0d] got %b want %b", i, v, exp_g[i]); end
        end
    endtask

    task automatic test_invalid();
        logic [1:0] v;
        load(5, 2'b01);
        start_sweep();
        for (int i = 0; i < 5; i++) send(2'b00, 0);
        send(2'b11, 1);
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL inv_err got %b want 1", err_sticky); end
        checks++; if (mut_count !== 16'd0) begin errors++; $display("FAIL inv_count got %0d want 0", mut_count); end
        for (int i = 6; i < GL; i++) send(2'b00, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL inv_done got %b want 1", done); end
        tick();
        rd(5, v);
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL inv_g5 got %b want 01", v); end
        start_sweep();
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL inv_clear got %b want 0", err_sticky); end
    endtask

    // Continues the sweep opened at the end of test_invalid.
    task automatic test_run_ignore();
        logic [1:0] v;
        int d0;
        d0 = done_cnt;
        send(2'b01, 0);
        send(2'b01, 0);
        start = 1'b1; ld_we = 1'b1; ld_addr = 5'd3; ld_trit = 2'b10;
        tick();
        start = 1'b0; ld_we = 1'b0;
        for (int i = 2; i < GL; i++) send(2'b00, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", done); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL ign_early_done got %0d want 0", done_cnt - d0); end
        tick();
        rd(3, v);
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL ign_g3 got %b want 01", v); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] v;
        int d0;
        start_sweep();
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) send(2'b01, 0);
        checks++; if (mut_count !== 16'd10) begin errors++; $display("FAIL mid_count_pre got %0d want 10", mut_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mut_ready !== 1'b0) begin errors++; $display("FAIL mid_idle got busy=%b ready=%b want 0/0", busy, mut_ready); end
        checks++; if (mut_count !== 16'd0) begin errors++; $display("FAIL mid_count got %0d want 0", mut_count); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < GL; i++) exp_g[i] = 2'b00;
        tick();
        for (int i = 0; i < GL; i++) begin
            rd(i, v);
            checks++; if (v !== 2'b00) begin errors++; $display("FAIL mid_trit[%0d] got %b want 00", i, v); end
        end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_done got %0d pulses want 0", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_single();
        test_full_sweep();
        test_invalid();
        test_run_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
